// File: rtl/regfile_hilo_if.sv
// rtl/regfile_hilo_if.sv - WB write buses and ID read ports of the GPR + HI/LO register file
interface regfile_hilo_if #(
  parameter int DW = 32,
  parameter int AW = 5
);
  // {we, waddr, wdata}
  logic [AW+DW:0]   wb_to_rf_bus;
  // {hi_we, lo_we, hi_i, lo_i}
  logic [2*DW+1:0]  wb_to_hilo_bus;
  logic [AW-1:0]    raddr1;
  logic [AW-1:0]    raddr2;
  logic [DW-1:0]    rdata1;
  logic [DW-1:0]    rdata2;
  logic [DW-1:0]    hi_o;
  logic [DW-1:0]    lo_o;

  // pipeline side: WB drives writes, ID drives read addresses and consumes data
  modport master (
    output wb_to_rf_bus, wb_to_hilo_bus, raddr1, raddr2,
    input  rdata1, rdata2, hi_o, lo_o
  );

  // register file side
  modport slave (
    input  wb_to_rf_bus, wb_to_hilo_bus, raddr1, raddr2,
    output rdata1, rdata2, hi_o, lo_o
  );
endinterface

// File: rtl/regfile_hilo.sv
// rtl/regfile_hilo.sv - 32-entry GPR file plus HI/LO pair; RF_BYPASS_EN selects write-first reads
module regfile_hilo #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic           clk,
  input  logic           rst,
  regfile_hilo_if.slave  rf
);
  localparam int DEPTH = 2 ** AW;

  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic          hi_we;
  logic          lo_we;
  logic [DW-1:0] hi_i;
  logic [DW-1:0] lo_i;

  // entry 0 is never written and resets to 0, so it stays constant zero
  logic [DEPTH-1:0][DW-1:0] gpr_q, gpr_d;
  logic [DW-1:0]            hi_q, hi_d;
  logic [DW-1:0]            lo_q, lo_d;

  logic [DW-1:0] rdata1;
  logic [DW-1:0] rdata2;
  logic [DW-1:0] hi_rd;
  logic [DW-1:0] lo_rd;
  logic          gpr_wr;

  assign {we, waddr, wdata}         = rf.wb_to_rf_bus;
  assign {hi_we, lo_we, hi_i, lo_i} = rf.wb_to_hilo_bus;
  assign gpr_wr = we && (waddr != '0);

  // next architectural state: GPR and HI/LO writes are independent and may coincide
  always_comb begin
    gpr_d = gpr_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    if (gpr_wr) gpr_d[waddr] = wdata;
    if (hi_we)  hi_d = hi_i;
    if (lo_we)  lo_d = lo_i;
  end

  // state registers; reset takes priority over any write in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      gpr_q <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      gpr_q <= gpr_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
    end
  end

  // combinational read ports; address 0 always reads zero, even when targeted by a write
  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if (rf.raddr1 != '0) rdata1 = gpr_q[rf.raddr1];
    if (rf.raddr2 != '0) rdata2 = gpr_q[rf.raddr2];
    hi_rd = hi_q;
    lo_rd = lo_q;
`ifdef RF_BYPASS_EN
    // write-first: the WB value is visible in its own cycle, so ID needs no WB forwarding
    if (gpr_wr && (waddr == rf.raddr1)) rdata1 = wdata;
    if (gpr_wr && (waddr == rf.raddr2)) rdata2 = wdata;
    if (hi_we) hi_rd = hi_i;
    if (lo_we) lo_rd = lo_i;
`else
    // read-old: stored values only; new data appears one cycle after the write
`endif
  end

  assign rf.rdata1 = rdata1;
  assign rf.rdata2 = rdata2;
  assign rf.hi_o   = hi_rd;
  assign rf.lo_o   = lo_rd;
endmodule

// File: tb/tb_regfile_hilo.sv
// tb/tb_regfile_hilo.sv - scoreboard bench for regfile_hilo, both RF_BYPASS_EN builds
`timescale 1ns/1ps
module tb_regfile_hilo;
  localparam int DW = 32;
  localparam int AW = 5;
`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_hilo_if #(.DW(DW), .AW(AW)) rf_if ();
  regfile_hilo #(.DW(DW), .AW(AW)) dut (.clk(clk), .rst(rst), .rf(rf_if));

  logic [31:0] m_gpr [32];
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  exp_t        exp_q [$];
  int          n_vec  = 0;
  int          n_miss = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_rd(input logic [4:0] a, input bit we,
                                           input logic [4:0] wa, input logic [31:0] wd);
    if (a == 5'd0) return 32'h0;
    if (BYP && we && (wa == a)) return wd;
    return m_gpr[a];
  endfunction

  // one pipeline cycle: drive, predict, sample at negedge, then advance the model at posedge
  task automatic cycle(input bit r, input bit we, input logic [4:0] wa, input logic [31:0] wd,
                       input bit hwe, input bit lwe, input logic [31:0] hi, input logic [31:0] lo,
                       input logic [4:0] a1, input logic [4:0] a2, input bit chk);
    exp_t e;
    rst = r;
    rf_if.wb_to_rf_bus   = {we, wa, wd};
    rf_if.wb_to_hilo_bus = {hwe, lwe, hi, lo};
    rf_if.raddr1 = a1;
    rf_if.raddr2 = a2;
    if (chk) begin
      e.r1 = model_rd(a1, we, wa, wd);
      e.r2 = model_rd(a2, we, wa, wd);
      e.hi = (BYP && hwe) ? hi : m_hi;
      e.lo = (BYP && lwe) ? lo : m_lo;
      exp_q.push_back(e);
    end
    @(negedge clk);
    if (chk) begin
      e = exp_q.pop_front();
      check_val($sformatf("rdata1[%0d]", a1), rf_if.rdata1, e.r1);
      check_val($sformatf("rdata2[%0d]", a2), rf_if.rdata2, e.r2);
      check_val("hi_o", rf_if.hi_o, e.hi);
      check_val("lo_o", rf_if.lo_o, e.lo);
    end
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 32; i++) m_gpr[i] = 32'h0;
      m_hi = 32'h0;
      m_lo = 32'h0;
    end else begin
      if (we && (wa != 5'd0)) m_gpr[wa] = wd;
      if (hwe) m_hi = hi;
      if (lwe) m_lo = lo;
    end
    #1;
  endtask

  task automatic rd(input logic [4:0] a1, input logic [4:0] a2);
    cycle(0, 0, 5'd0, 32'h0, 0, 0, 32'h0, 32'h0, a1, a2, 1);
  endtask

  task automatic wr(input logic [4:0] wa, input logic [31:0] wd, input logic [4:0] a1, input logic [4:0] a2);
    cycle(0, 1, wa, wd, 0, 0, 32'h0, 32'h0, a1, a2, 1);
  endtask

  task automatic read_all();
    for (int i = 0; i < 16; i++) rd(5'(i), 5'(i + 16));
  endtask

  initial begin
    logic [4:0]  a1, a2, wa;
    logic [31:0] wd, hi, lo;
    bit          we, hwe, lwe, r;
    for (int i = 0; i < 32; i++) m_gpr[i] = 32'h0;
    m_hi = 32'h0;
    m_lo = 32'h0;
    @(posedge clk);
    #1;

    // power-up reset, then every register reads zero
    cycle(1, 0, 5'd0, 32'h0, 0, 0, 32'h0, 32'h0, 5'd0, 5'd0, 0);
    read_all();

    // random writes, one reset cycle, then everything is zero again
    for (int i = 0; i < 24; i++)
      cycle(0, 1, 5'($urandom_range(0, 31)), $urandom, 1, 1, $urandom, $urandom,
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 1);
    cycle(1, 0, 5'd0, 32'h0, 0, 0, 32'h0, 32'h0, 5'd0, 5'd0, 0);
    read_all();

    // basic write and read-back
    wr(5'd5, 32'hDEADBEEF, 5'd5, 5'd0);
    rd(5'd5, 5'd5);

    // writes to register 0 are dropped, including the same-cycle view
    wr(5'd0, 32'h12345678, 5'd0, 5'd0);
    rd(5'd0, 5'd0);

    // write address equals both read addresses
    wr(5'd7, 32'h1, 5'd0, 5'd0);
    wr(5'd7, 32'h2, 5'd7, 5'd7);
    rd(5'd7, 5'd7);

    // top entry
    wr(5'd31, 32'hCAFEF00D, 5'd31, 5'd30);
    rd(5'd31, 5'd30);

    // HI only, then HI and LO together
    cycle(0, 0, 5'd0, 32'h0, 1, 0, 32'hA, 32'hB, 5'd0, 5'd0, 1);
    rd(5'd0, 5'd0);
    cycle(0, 0, 5'd0, 32'h0, 1, 1, 32'h1, 32'h2, 5'd0, 5'd0, 1);
    rd(5'd0, 5'd0);
    // LO only
    cycle(0, 0, 5'd0, 32'h0, 0, 1, 32'h77, 32'h99, 5'd0, 5'd0, 1);
    rd(5'd0, 5'd0);

    // GPR and HI/LO writes in the same cycle both commit
    cycle(0, 1, 5'd9, 32'h0BADCAFE, 1, 1, 32'h11111111, 32'h22222222, 5'd9, 5'd5, 1);
    rd(5'd9, 5'd5);

    // reset beats a coincident write
    wr(5'd3, 32'h55, 5'd3, 5'd0);
    cycle(1, 1, 5'd3, 32'hFF, 1, 1, 32'h3, 32'h4, 5'd3, 5'd3, 0);
    rd(5'd3, 5'd5);

    // random traffic against the model, with occasional resets
    for (int i = 0; i < 400; i++) begin
      r   = ($urandom_range(0, 49) == 0);
      we  = $urandom_range(0, 3) != 0;
      wa  = 5'($urandom_range(0, 31));
      wd  = $urandom;
      hwe = $urandom_range(0, 2) == 0;
      lwe = $urandom_range(0, 2) == 0;
      hi  = $urandom;
      lo  = $urandom;
      a1  = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      a2  = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      cycle(r, we, wa, wd, hwe, lwe, hi, lo, a1, a2, !r);
    end
    read_all();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
